stap_hsk_rx: RTL and testbench

STAP_HSK_RX -- requirements
Module: stap_hsk_rx

---
 rtl/stap_hsk_pkg.sv | 14 +
 rtl/stap_hsk_sync.sv | 24 ++
 rtl/stap_hsk_rx.sv | 113 +++++++++++
 tb/tb_stap_hsk_rx.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/stap_hsk_pkg.sv
// Shared types for the 4-phase handshake receiver.
// Holds the FSM state enum and the transfer counter width.
package stap_hsk_pkg;

    localparam int XFER_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        ACK_HI  = 2'd2,
        WAIT_LO = 2'd3
    } hsk_state_e;

endpackage

// File: rtl/stap_hsk_sync.sv
// Multi-flop synchronizer for a single asynchronous bit.
// Async active-high reset clears every stage to 0.
module stap_hsk_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic ck,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/stap_hsk_rx.sv
// 4-phase handshake receiver: syncs req, captures payload, acks.
// Define STAP_HSK_RX_SKID_EN to ack at capture, decoupled from out_ready.
module stap_hsk_rx
    import stap_hsk_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  ck,
    input  logic                  rst,
    input  logic                  req_async,
    input  logic [DATA_W-1:0]     data_async,
    output logic                  ack,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    input  logic                  out_ready,
    output logic                  proto_err,
    output logic [XFER_CNT_W-1:0] xfer_cnt
);

    logic                  req_s;
    hsk_state_e            state;
    hsk_state_e            state_n;
    logic                  ack_n;
    logic                  valid_n;
    logic [DATA_W-1:0]     data_n;
    logic                  perr_n;
    logic [XFER_CNT_W-1:0] cnt_n;

    stap_hsk_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .ck  (ck),
        .rst (rst),
        .d   (req_async),
        .q   (req_s)
    );

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ack       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            proto_err <= 1'b0;
            xfer_cnt  <= '0;
        end else begin
            state     <= state_n;
            ack       <= ack_n;
            out_valid <= valid_n;
            out_data  <= data_n;
            proto_err <= perr_n;
            xfer_cnt  <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        ack_n   = ack;
        valid_n = out_valid;
        data_n  = out_data;
        perr_n  = proto_err;
        cnt_n   = xfer_cnt;
`ifdef STAP_HSK_RX_SKID_EN
        // Local side drains on its own; the source is acked at capture.
        if (out_valid && out_ready) begin
            valid_n = 1'b0;
        end
`endif
        unique case (state)
            IDLE: begin
`ifdef STAP_HSK_RX_SKID_EN
                if (req_s && !out_valid) begin
                    data_n  = data_async;
                    valid_n = 1'b1;
                    ack_n   = 1'b1;
                    state_n = ACK_HI;
                end
`else
                if (req_s) begin
                    data_n  = data_async;
                    valid_n = 1'b1;
                    state_n = PRESENT;
                end
`endif
            end
            PRESENT: begin
                if (!req_s) begin
                    perr_n = 1'b1;
                end
                if (out_valid && out_ready) begin
                    valid_n = 1'b0;
                    ack_n   = 1'b1;
                    state_n = ACK_HI;
                end
            end
            ACK_HI: begin
                if (!req_s) begin
                    ack_n   = 1'b0;
                    cnt_n   = xfer_cnt + XFER_CNT_W'(1);
                    state_n = WAIT_LO;
                end
            end
            WAIT_LO: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_stap_hsk_rx.sv
// Directed + randomized bench for stap_hsk_rx with a scoreboard model.
// Covers latency, hold, wrap, withdrawal, reset and the skid build.
module tb_stap_hsk_rx;

    localparam int DW = 32;
    localparam int SYNC_STAGES = 2;

    logic          ck = 1'b0;
    logic          rst = 1'b1;
    logic          req_async = 1'b0;
    logic [DW-1:0] data_async = '0;
    logic          ack;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b0;
    logic          proto_err;
    logic [7:0]    xfer_cnt;

    int vectors = 0;
    int miscompares = 0;
    int exp_cnt = 0;
    logic exp_perr = 1'b0;
    logic [DW-1:0] sb[$];

    stap_hsk_rx #(
        .DATA_W      (DW),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .ck         (ck),
        .rst        (rst),
        .req_async  (req_async),
        .data_async (data_async),
        .ack        (ack),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .proto_err  (proto_err),
        .xfer_cnt   (xfer_cnt)
    );

    always #5 ck = ~ck;

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (out_valid !== 1'b1 && n < 20);
    endtask

    task automatic wait_ack_low();
        int n;
        n = 0;
        while (ack !== 1'b0 && n < 20) begin
            step();
            n++;
        end
        chk("ack_low", {63'd0, ack}, 64'd0);
    endtask

    task automatic count_done();
        exp_cnt = (exp_cnt + 1) % 256;
        chk("xfer_cnt", {56'd0, xfer_cnt}, 64'(exp_cnt));
    endtask

    task automatic xfer(input logic [DW-1:0] d, input int rdly);
        int n;
        logic [DW-1:0] e;
        sb.push_back(d);
        data_async = d;
        req_async  = 1'b1;
        out_ready  = (rdly == 0);
        wait_valid(n);
        chk("latency", 64'(n), 64'(SYNC_STAGES + 1));
        e = sb.pop_front();
        chk("data", {32'd0, out_data}, {32'd0, e});
        for (int i = 0; i < rdly; i++) begin
            chk("hold_valid", {63'd0, out_valid}, 64'd1);
            chk("hold_data", {32'd0, out_data}, {32'd0, e});
            chk("hold_ack", {63'd0, ack}, 64'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        chk("ack_high", {63'd0, ack}, 64'd1);
        chk("valid_clr", {63'd0, out_valid}, 64'd0);
        out_ready  = 1'b0;
        req_async  = 1'b0;
        data_async = $urandom;
        wait_ack_low();
        count_done();
        chk("proto_err", {63'd0, proto_err}, {63'd0, exp_perr});
    endtask

    initial begin
        int n;
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;

        step();
        step();
        chk("rst_ack", {63'd0, ack}, 64'd0);
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_data", {32'd0, out_data}, 64'd0);
        chk("rst_perr", {63'd0, proto_err}, 64'd0);
        chk("rst_cnt", {56'd0, xfer_cnt}, 64'd0);
        rst = 1'b0;
        step();

`ifdef STAP_HSK_RX_SKID_EN
        d1 = $urandom;
        data_async = d1;
        req_async  = 1'b1;
        out_ready  = 1'b0;
        wait_valid(n);
        chk("s_latency", 64'(n), 64'(SYNC_STAGES + 1));
        chk("s_ack_with_valid", {63'd0, ack}, 64'd1);
        chk("s_data1", {32'd0, out_data}, {32'd0, d1});
        req_async = 1'b0;
        wait_ack_low();
        count_done();
        d2 = $urandom;
        data_async = d2;
        req_async  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("s_block_valid", {63'd0, out_valid}, 64'd1);
            chk("s_block_data", {32'd0, out_data}, {32'd0, d1});
            chk("s_block_ack", {63'd0, ack}, 64'd0);
        end
        out_ready = 1'b1;
        step();
        chk("s_drain", {63'd0, out_valid}, 64'd0);
        out_ready = 1'b0;
        step();
        chk("s_cap2_valid", {63'd0, out_valid}, 64'd1);
        chk("s_cap2_ack", {63'd0, ack}, 64'd1);
        chk("s_cap2_data", {32'd0, out_data}, {32'd0, d2});
        req_async = 1'b0;
        wait_ack_low();
        count_done();
        out_ready = 1'b1;
        step();
        chk("s_drain2", {63'd0, out_valid}, 64'd0);
        out_ready = 1'b0;
`else
        // Test 1 and Test 2
        xfer(32'hA5A5_0001, 0);
        xfer($urandom, 10);

        // Test 3: 256 transfers from a clean count
        rst = 1'b1;
        #1;
        rst = 1'b0;
        exp_cnt = 0;
        step();
        for (int i = 0; i < 256; i++) begin
            xfer($urandom, int'($urandom_range(0, 3)));
        end
        chk("wrap_zero", {56'd0, xfer_cnt}, 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        // Test 4: source withdraws while payload is presented
        d1 = $urandom;
        data_async = d1;
        req_async  = 1'b1;
        out_ready  = 1'b0;
        wait_valid(n);
        chk("w_latency", 64'(n), 64'(SYNC_STAGES + 1));
        chk("w_data", {32'd0, out_data}, {32'd0, d1});
        req_async = 1'b0;
        step();
        step();
        chk("perr_early", {63'd0, proto_err}, 64'd0);
        step();
        chk("perr_set", {63'd0, proto_err}, 64'd1);
        exp_perr = 1'b1;
        out_ready = 1'b1;
        step();
        chk("w_ack_hi", {63'd0, ack}, 64'd1);
        out_ready = 1'b0;
        step();
        chk("w_ack_drop", {63'd0, ack}, 64'd0);
        count_done();
        xfer($urandom, 2);
        chk("perr_sticky", {63'd0, proto_err}, 64'd1);

        // Test 5: reset while ack is high and req still high
        d2 = $urandom;
        data_async = d2;
        req_async  = 1'b1;
        out_ready  = 1'b1;
        wait_valid(n);
        step();
        chk("r_ack_hi", {63'd0, ack}, 64'd1);
        rst = 1'b1;
        #1;
        chk("r_ack", {63'd0, ack}, 64'd0);
        chk("r_perr", {63'd0, proto_err}, 64'd0);
        chk("r_cnt", {56'd0, xfer_cnt}, 64'd0);
        chk("r_valid", {63'd0, out_valid}, 64'd0);
        exp_cnt  = 0;
        exp_perr = 1'b0;
        rst = 1'b0;
        out_ready = 1'b0;
        wait_valid(n);
        chk("r_recap_lat", 64'(n), 64'(SYNC_STAGES + 1));
        chk("r_recap_data", {32'd0, out_data}, {32'd0, d2});
        out_ready = 1'b1;
        step();
        chk("r_ack2", {63'd0, ack}, 64'd1);
        out_ready = 1'b0;
        req_async = 1'b0;
        wait_ack_low();
        count_done();
        chk("r_perr_after", {63'd0, proto_err}, 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
